// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers the HPS ROM download stream into the Scramble ROM
// regions, counts and validates the image, and owns the core reset.
// Regions are packed back to back from address 0: CPU, SND, GFX, PROM.
module rom_load_ctrl #(
    parameter logic [15:0] CPU_SIZE    = 16'h4000,
    parameter logic [15:0] SND_SIZE    = 16'h1800,
    parameter logic [15:0] GFX_SIZE    = 16'h1000,
    parameter logic [15:0] PROM_SIZE   = 16'h0020,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        rst_req,
    output logic [3:0]  rom_wr,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        rom_valid,
    output logic        load_err
);

    // 17-bit region map so a full 64 KiB image (END = 0x10000) still compares correctly
    localparam logic [16:0] SND_BASE  = {1'b0, CPU_SIZE};
    localparam logic [16:0] GFX_BASE  = SND_BASE  + {1'b0, SND_SIZE};
    localparam logic [16:0] PROM_BASE = GFX_BASE  + {1'b0, GFX_SIZE};
    localparam logic [16:0] END_ADDR  = PROM_BASE + {1'b0, PROM_SIZE};
    localparam logic [16:0] CNT_MAX   = 17'h1FFFF;
    localparam logic [15:0] HOLD_LOAD = HOLD_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    // Power-up values come from declaration initialisers; RESET never clears the image status.
    state_t      state_q      = S_IDLE;
    state_t      state_d;
    logic [15:0] hold_q       = '0;
    logic [15:0] hold_d;
    logic [16:0] cnt_q        = '0;
    logic [16:0] cnt_d;
    logic        err_oob_q    = 1'b0;
    logic        err_oob_d;
    logic        rom_valid_q  = 1'b0;
    logic        rom_valid_d;
    logic        load_err_q   = 1'b0;
    logic        load_err_d;
    logic [3:0]  rom_wr_q     = '0;
    logic [3:0]  rom_wr_d;
    logic [13:0] rom_addr_q   = '0;
    logic [13:0] rom_addr_d;
    logic [7:0]  rom_data_q   = '0;
    logic        core_reset_q = 1'b1;

    logic [16:0] addr17;
    logic [3:0]  hit;
    logic [13:0] base_lo;
    logic        in_range;
    logic        oob;
    logic        wr_en;
    logic        entering;
    logic [16:0] cnt_base;
    logic [16:0] cnt_nxt;
    logic        oob_nxt;
    logic        img_ok;

    assign addr17 = {1'b0, dn_addr};

    // Region decode: one-hot hit and the low 14 bits of the region base
    always_comb begin
        hit     = 4'b0000;
        base_lo = '0;
        if (addr17 < SND_BASE) begin
            hit     = 4'b0001;
            base_lo = '0;
        end else if (addr17 < GFX_BASE) begin
            hit     = 4'b0010;
            base_lo = SND_BASE[13:0];
        end else if (addr17 < PROM_BASE) begin
            hit     = 4'b0100;
            base_lo = GFX_BASE[13:0];
        end else if (addr17 < END_ADDR) begin
            hit     = 4'b1000;
            base_lo = PROM_BASE[13:0];
        end
    end

    assign in_range = |hit;
    assign oob      = (addr17 >= END_ADDR);

    // A strobe counts in LOAD, or in the cycle that moves any other state into LOAD.
    assign entering = (state_q != S_LOAD) && dn_download;
    assign wr_en    = dn_wr && !RESET && ((state_q == S_LOAD) || dn_download);

    // Counter and out-of-map flag restart on LOAD entry but still see the entry-cycle write.
    assign cnt_base = entering ? '0 : cnt_q;
    assign cnt_nxt  = (wr_en && in_range && (cnt_base != CNT_MAX)) ? cnt_base + 17'd1 : cnt_base;
    assign oob_nxt  = (entering ? 1'b0 : err_oob_q) | (wr_en && oob);
    assign img_ok   = (cnt_nxt >= END_ADDR) && !oob_nxt;

    // Write path next state: region strobe and local address for in-range bytes only
    always_comb begin
        rom_wr_d   = 4'b0000;
        rom_addr_d = rom_addr_q;
        if (wr_en && in_range) begin
            rom_wr_d   = hit;
            rom_addr_d = dn_addr[13:0] - base_lo;
        end
    end

    // Sequencer next state: download has priority over soft reset everywhere
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_nxt;
        err_oob_d   = oob_nxt;
        rom_valid_d = rom_valid_q;
        load_err_d  = load_err_q;
        if (RESET) begin
            state_d   = rom_valid_q ? S_HOLD : S_IDLE;
            hold_d    = HOLD_LOAD;
            cnt_d     = '0;
            err_oob_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dn_download) begin
                        state_d     = S_LOAD;
                        rom_valid_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!dn_download) begin
                        rom_valid_d = img_ok;
                        load_err_d  = !img_ok;
                        state_d     = img_ok ? S_HOLD : S_IDLE;
                        hold_d      = HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (dn_download) begin
                        state_d     = S_LOAD;
                        rom_valid_d = 1'b0;
                    end else if (rst_req) begin
                        hold_d = HOLD_LOAD;
                    end else if (hold_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                S_RUN: begin
                    if (dn_download) begin
                        state_d     = S_LOAD;
                        rom_valid_d = 1'b0;
                    end else if (rst_req) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer and image-status registers
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        hold_q      <= hold_d;
        cnt_q       <= cnt_d;
        err_oob_q   <= err_oob_d;
        rom_valid_q <= rom_valid_d;
        load_err_q  <= load_err_d;
    end

    // Registered write port and core reset; core runs only in RUN
    always_ff @(posedge clk) begin
        rom_wr_q     <= rom_wr_d;
        rom_addr_q   <= rom_addr_d;
        core_reset_q <= (state_d != S_RUN);
        if (wr_en && in_range) begin
            rom_data_q <= dn_data;
        end
    end

    assign rom_wr     = rom_wr_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign core_reset = core_reset_q;
    assign rom_valid  = rom_valid_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl. Region sizes are scaled down so full downloads stay
// short; the map keeps the same shape (CPU, SND, GFX, PROM back to back) and the
// hold length stays at 1024 cycles.
module tb_rom_load_ctrl;

    localparam logic [15:0] CPU  = 16'h0100;
    localparam logic [15:0] SND  = 16'h0080;
    localparam logic [15:0] GFX  = 16'h0040;
    localparam logic [15:0] PROM = 16'h0020;
    localparam logic [15:0] HOLD = 16'd1024;
    localparam int B1   = 32'h0100;
    localparam int B2   = 32'h0180;
    localparam int B3   = 32'h01C0;
    localparam int ENDA = 32'h01E0;

    logic        clk;
    logic        RESET;
    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        rst_req;
    logic [3:0]  rom_wr;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        rom_valid;
    logic        load_err;

    typedef struct packed {
        logic [3:0]  wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    rom_load_ctrl #(
        .CPU_SIZE(CPU), .SND_SIZE(SND), .GFX_SIZE(GFX), .PROM_SIZE(PROM), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .RESET(RESET), .dn_download(dn_download), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .rst_req(rst_req),
        .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_reset(core_reset), .rom_valid(rom_valid), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every ROM strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rom_wr !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rom_wr_unexpected got wr=%b addr=%h data=%h required no write",
                         rom_wr, rom_addr, rom_data);
            end else begin
                mon_e = sb.pop_front();
                if ({rom_wr, rom_addr, rom_data} !== mon_e) begin
                    errors++;
                    $display("FAIL rom_write got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                             rom_wr, rom_addr, rom_data, mon_e.wr, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int a, output logic [3:0] wr, output logic [13:0] la);
        if (a < B1) begin
            wr = 4'b0001; la = 14'(a);
        end else if (a < B2) begin
            wr = 4'b0010; la = 14'(a - B1);
        end else if (a < B3) begin
            wr = 4'b0100; la = 14'(a - B2);
        end else if (a < ENDA) begin
            wr = 4'b1000; la = 14'(a - B3);
        end else begin
            wr = 4'b0000; la = '0;
        end
    endfunction

    // Counts cycles the core stays in reset, starting at the next falling edge
    task automatic count_hold(output int n);
        n = 0;
        @(negedge clk);
        while (core_reset === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_hold(input string name);
        int n;
        count_hold(n);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL %s hold got %0d cycles required 1024", name, n);
        end
    endtask

    // One download of bytes 0..last, first strobe in the same cycle as dn_download rises
    task automatic do_download(input string name, input int last, input int gap, input bit add_oob);
        logic [3:0]  wr;
        logic [13:0] la;
        logic [7:0]  d;
        int  cnt = 0;
        bit  exp_valid;
        dn_download = 1'b1;
        for (int a = 0; a <= last; a++) begin
            d = 8'($urandom);
            dn_wr = 1'b1; dn_addr = 16'(a); dn_data = d;
            model(a, wr, la);
            if (wr != 4'b0000) begin
                sb.push_back({wr, la, d});
                cnt++;
            end
            tick();
            dn_wr = 1'b0;
            if (a == 0) begin
                checks++;
                if (rom_valid !== 1'b0 || core_reset !== 1'b1) begin
                    errors++;
                    $display("FAIL %s load_entry got valid=%b core_reset=%b required 0 1",
                             name, rom_valid, core_reset);
                end
            end
            repeat (gap) tick();
        end
        if (add_oob) begin
            dn_wr = 1'b1; dn_addr = 16'(ENDA); dn_data = 8'hA5;
            tick();
            dn_wr = 1'b0;
            repeat (gap) tick();
        end
        dn_download = 1'b0;
        tick();
        exp_valid = (cnt >= ENDA) && !add_oob;
        checks++;
        if (rom_valid !== exp_valid || load_err !== !exp_valid) begin
            errors++;
            $display("FAIL %s status got valid=%b err=%b required valid=%b err=%b",
                     name, rom_valid, load_err, exp_valid, !exp_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got %0d pending required 0", name, sb.size());
        end
    endtask

    task automatic check_stuck_reset(input string name);
        repeat (1100) tick();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_reset got core_reset=%b required 1", name, core_reset);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (core_reset !== 1'b1 || rom_valid !== 1'b0 || rom_wr !== 4'b0000 || load_err !== 1'b0) begin
                errors++;
                $display("FAIL powerup got core_reset=%b valid=%b wr=%b err=%b required 1 0 0000 0",
                         core_reset, rom_valid, rom_wr, load_err);
            end
        end
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_stuck_reset("reset_idle");
    endtask

    task automatic test_full_download();
        do_download("full", ENDA - 1, 3, 1'b0);
        check_hold("full");
        checks++;
        if (core_reset !== 1'b0) begin
            errors++;
            $display("FAIL full run got core_reset=%b required 0", core_reset);
        end
    endtask

    task automatic test_rst_req();
        tick();
        rst_req = 1'b1;
        tick();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL rst_req rise got core_reset=%b required 1", core_reset);
        end
        repeat (2) tick();
        rst_req = 1'b0;
        check_hold("rst_req");
        tick();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        repeat (500) tick();
        checks++;
        if (core_reset !== 1'b1) begin
            errors++;
            $display("FAIL rst_req midhold got core_reset=%b required 1", core_reset);
        end
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        check_hold("rst_req_restart");
    endtask

    task automatic test_reset_run();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_hold("reset_run");
        checks++;
        if (rom_valid !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_run status got valid=%b err=%b core_reset=%b required 1 0 0",
                     rom_valid, load_err, core_reset);
        end
    endtask

    task automatic test_short_download();
        tick();
        do_download("short", B3 - 1, 3, 1'b0);
        check_stuck_reset("short");
    endtask

    task automatic test_oob();
        do_download("oob", ENDA - 1, 1, 1'b1);
        check_stuck_reset("oob");
    endtask

    task automatic test_back_to_back();
        do_download("b2b_first", ENDA - 1, 0, 1'b0);
        repeat (10) tick();
        do_download("b2b_second", ENDA - 1, 0, 1'b0);
        check_hold("b2b");
    endtask

    task automatic test_reset_load();
        logic [3:0]  wr;
        logic [13:0] la;
        tick();
        dn_download = 1'b1;
        for (int a = 0; a < 3; a++) begin
            dn_wr = 1'b1; dn_addr = 16'(B1 + a); dn_data = 8'(8'h30 + a);
            model(B1 + a, wr, la);
            sb.push_back({wr, la, 8'(8'h30 + a)});
            tick();
            dn_wr = 1'b0;
            tick();
        end
        RESET = 1'b1;
        dn_download = 1'b0;
        tick();
        RESET = 1'b0;
        checks++;
        if (rom_valid !== 1'b0 || load_err !== 1'b0 || core_reset !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_load got valid=%b err=%b core_reset=%b pending=%0d required 0 0 1 0",
                     rom_valid, load_err, core_reset, sb.size());
        end
        check_stuck_reset("reset_load");
    endtask

    initial begin
        RESET = 1'b0; dn_download = 1'b0; dn_wr = 1'b0;
        dn_addr = '0; dn_data = '0; rst_req = 1'b0;
        test_reset();
        test_full_download();
        test_rst_req();
        test_reset_run();
        test_short_download();
        test_oob();
        test_back_to_back();
        test_reset_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ROM download stream into the Scramble core's ROM regions and gates the core's reset around it.
- Sits between hps_io (ioctl_*) and scramble_top (dn_* and RESET).
- Decodes each download byte to a region-local write strobe.
- Counts bytes per region and validates the image.
- Holds the core in reset during and after a download, and stretches soft-reset requests.

Parameters:
- CPU_SIZE, 16'h4000: main CPU ROM bytes; region 0 starts at 0.
- SND_SIZE, 16'h1800: sound CPU ROM bytes; follows region 0.
- GFX_SIZE, 16'h1000: tile/sprite ROM bytes; follows region 1.
- PROM_SIZE, 16'h0020: colour PROM bytes; follows region 2.
- HOLD_CYCLES, 16'd1024: clk cycles the core reset is held after a download or reset request ends.

Ports:
- clk, in, 1: system clock (clk_sys domain).
- RESET, in, 1: synchronous, active-high controller reset.
- dn_download, in, 1: HPS download active.
- dn_wr, in, 1: one-cycle byte strobe.
- dn_addr, in, 16: download byte address.
- dn_data, in, 8: download byte.
- rst_req, in, 1: soft reset request (menu/button), level.
- rom_wr, out, 4: one-hot region write strobe (bit0 CPU, bit1 SND, bit2 GFX, bit3 PROM).
- rom_addr, out, 14: region-local byte address.
- rom_data, out, 8: byte to write.
- core_reset, out, 1: reset to scramble_top.
- rom_valid, out, 1: last download complete and in range.
- load_err, out, 1: last download wrote outside the map or was short.

Behaviour:
- Region bases are derived: SND_BASE=CPU_SIZE, GFX_BASE=SND_BASE+SND_SIZE, PROM_BASE=GFX_BASE+GFX_SIZE, END=PROM_BASE+PROM_SIZE. Comparisons are 17-bit, so END=0x10000 is legal.
- Write path, registered, latency 1:
  - dn_wr=1 with dn_addr in [base, base+size) → next cycle: rom_wr one-hot for that region, rom_addr=dn_addr-base (low 14 bits), rom_data=dn_data.
  - rom_wr is otherwise 0; rom_addr/rom_data hold their last value.
  - dn_wr with dn_addr>=END → rom_wr=0 and sticky err_oob set.
  - dn_wr is honoured only in LOAD.
- Byte counter, 17 bits: cleared on LOAD entry; +1 per accepted in-range write; saturates at 17'h1FFFF.
- FSM:
  - IDLE (no valid image): core_reset=1. dn_download=1 → LOAD.
  - LOAD: core_reset=1; rom_valid=0 on entry; err_oob cleared on entry. When dn_download falls:
    - rom_valid=(count>=END && !err_oob)
    - load_err=!rom_valid
    - next state = HOLD if rom_valid, else IDLE.
  - HOLD: core_reset=1; down-counter loaded with HOLD_CYCLES-1 on entry, decrements each cycle; at 0 → RUN. dn_download=1 → LOAD (priority over the countdown). rst_req=1 reloads the counter.
  - RUN: core_reset=0. dn_download=1 → LOAD; else rst_req=1 → HOLD.
- Simultaneous events:
  - dn_download has priority over rst_req in every state.
  - A dn_wr in the same cycle as LOAD entry is accepted (it is decoded from the IDLE/HOLD/RUN→LOAD transition cycle).
- RESET=1, synchronous:
  - state → HOLD with counter reloaded if rom_valid=1, else IDLE.
  - rom_wr=0, core_reset=1, counter and err_oob cleared.
  - rom_valid and load_err are kept (image in BRAM survives a controller reset).
- Power-up values, via init: state IDLE, rom_valid=0, load_err=0, rom_addr=0, rom_data=0, rom_wr=0, core_reset=1.
- RESET asserted mid-LOAD → IDLE (rom_valid was cleared on LOAD entry); a download still active re-enters LOAD the next cycle and restarts counting.

Test Plan:
- Power-up, no download, 100 cycles → core_reset=1, rom_valid=0, rom_wr=0 throughout.
- Full download 0x0000–0x681F, one dn_wr every 4 cycles → rom_wr=0001 for addr 0x3FFF (rom_addr 0x3FFF), rom_wr=0010 for 0x4000 (rom_addr 0), rom_wr=1000 for 0x681F (rom_addr 0x1F); after fall, rom_valid=1, core_reset=1 for exactly 1024 cycles, then 0.
- Download stopping at 0x67FF (26624 bytes) → rom_valid=0, load_err=1, state IDLE, core_reset stays 1.
- Download including a write to 0x6820 → that write gives no rom_wr; load_err=1 at end despite a full count.
- RUN, rst_req pulsed 3 cycles → core_reset rises next cycle, falls 1024 cycles after rst_req drops; rst_req re-asserted mid-HOLD restarts the count.
- RUN with rom_valid=1, RESET 1 cycle → HOLD, 1024-cycle hold, back to RUN; rom_valid stays 1. RESET during LOAD → IDLE; rom_valid=0.
